credit_dispatch: RTL and testbench
==================================

Name: credit_dispatch

Overview:
- Responder end of the max-index selection path. Holds four WIDTH-bit credit counters (credit_a..credit_d) that drive the four-input max-index selector.
- Accepts the 2-bit index the selector returns, using a valid/ready handshake.
- Decrements the chosen counter and issues a registered one-hot grant.
- Refills all counters when they are exhausted or when refill is requested.

Parameters:
- WIDTH, 3, credit counter width; must match the selector operand width.
- INIT_CREDIT, 7, value loaded into every counter at reset and at refill completion; must be ≤ 2^WIDTH-1.
- REFILL_CYCLES, 4, number of cycles spent in REFILL before counters reload; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- idx_valid  input  1  index from the selector is valid.
- idx  input  2  selected index; 0=a, 1=b, 2=c, 3=d.
- idx_ready  output  1  block can accept an index this cycle.
- refill_req  input  1  request to reload all credits.
- credit_a, credit_b, credit_c, credit_d  output  WIDTH each  current credit values, sent to the selector.
- grant  output  4  one-hot grant; bit i corresponds to index i.
- grant_valid  output  1  grant/grant_err qualifier; one-cycle pulse.
- grant_err  output  1  index was accepted but its credit was already 0.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- One clock domain. reset is synchronous and active-high; it is sampled on the rising edge of clk and overrides all other inputs.
- Reset values:
  - state = IDLE
  - all credits = INIT_CREDIT
  - grant = 0, grant_valid = 0, grant_err = 0, busy = 0
  - refill counter = 0
  - idx_ready = 1 after the reset cycle
- FSM states: IDLE, GRANT, REFILL.
- IDLE:
  - idx_ready = 1 unless refill_req = 1.
  - Handshake happens when idx_valid & idx_ready at a rising edge.
  - refill_req = 1 takes priority over idx_valid in the same cycle: go to REFILL, idx_ready = 0, no index is accepted.
  - On handshake with credit[idx] > 0: credit[idx] <= credit[idx]-1 on that edge; latch idx; go to GRANT.
  - On handshake with credit[idx] == 0: no decrement (credits saturate at 0, never wrap); latch the error flag; go to GRANT.
- GRANT (exactly one cycle):
  - grant_valid = 1.
  - grant = one-hot of the latched idx, or 4'b0000 if in error.
  - grant_err = the latched error flag.
  - idx_ready = 0.
  - Next state: REFILL if all four credits are 0, otherwise IDLE. refill_req is ignored in this state.
- Handshake-to-grant latency: exactly 1 cycle. Maximum throughput: one index every 2 cycles.
- REFILL:
  - idx_ready = 0; idx_valid and refill_req are ignored.
  - The counter counts 0..REFILL_CYCLES-1.
  - On the edge where the counter = REFILL_CYCLES-1: all credits <= INIT_CREDIT, counter <= 0, go to IDLE.
- Outputs:
  - grant, grant_valid and grant_err are registered and are 0 in every state except GRANT.
  - credit_* are driven directly from the registers, so a decrement is visible the cycle after the handshake.
  - busy = (state != IDLE).
- Reset asserted mid-GRANT or mid-REFILL: the next state is IDLE with reset values; no grant is emitted.
- idx_valid may stay high across the GRANT and REFILL cycles. No handshake occurs because idx_ready is low, and the index is consumed only once per handshake.

Decomposition:
- Shared package: FSM state typedef (IDLE/GRANT/REFILL), a constant for the index width (2), and a constant for the number of lanes (4).
- One natural sub-module: credit_counter, a WIDTH-bit saturating down-counter.
  - Inputs: dec, load, load value.
  - Output: zero flag.
  - Instantiate four copies.
- The one-hot decode and the FSM stay in the top level.

Test Plan:
1. Reset, then idle 2 cycles -> all credits = 7, idx_ready = 1, grant_valid = 0, busy = 0.
2. idx = 2 with idx_valid for 1 cycle -> next cycle grant = 4'b0100, grant_valid = 1, grant_err = 0, credit_c = 6; the cycle after that, idx_ready = 1.
3. Hold idx_valid high with idx = 0 for 14 handshakes -> credit_a counts 7..0. Handshake 8 gives grant_err = 1, grant = 0, credit_a stays 0 (no wrap).
4. Drain all four credits to 0 -> the final GRANT is followed by 4 REFILL cycles with idx_ready = 0 and busy = 1; then all credits = 7 and state is IDLE.
5. refill_req and idx_valid (idx = 1) in the same IDLE cycle -> no grant, credit_b unchanged, REFILL entered, 4 cycles later credits = 7.
6. Assert reset on the 2nd REFILL cycle, after partial drain (credit_a = 3) -> next cycle: credits = 7, IDLE, grant_valid = 0, idx_ready = 1.

Source files
------------

// File: rtl/credit_dispatch_pkg.sv
// Shared types and constants for the credit dispatch responder.
package credit_dispatch_pkg;

  localparam int IDX_W = 2;
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    REFILL = 2'd2
  } state_t;

  function automatic logic [LANES-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/credit_dispatch_counter.sv
// Saturating WIDTH-bit down-counter holding one lane's credit.
module credit_counter #(
  parameter int WIDTH = 3,
  parameter int INIT  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset)
      count <= WIDTH'(INIT);
    else if (load)
      count <= load_val;
    else if (dec && !zero)
      count <= count - WIDTH'(1);
  end

endmodule

// File: rtl/credit_dispatch.sv
// Accepts selector indices, spends per-lane credits, issues one-hot grants
// and reloads credits after exhaustion or on request.
module credit_dispatch
  import credit_dispatch_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int INIT_CREDIT   = 7,
  parameter int REFILL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idx_valid,
  input  logic [IDX_W-1:0] idx,
  output logic             idx_ready,
  input  logic             refill_req,
  output logic [WIDTH-1:0] credit_a,
  output logic [WIDTH-1:0] credit_b,
  output logic [WIDTH-1:0] credit_c,
  output logic [WIDTH-1:0] credit_d,
  output logic [LANES-1:0] grant,
  output logic             grant_valid,
  output logic             grant_err,
  output logic             busy
);

  localparam int CNT_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFILL_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] rcnt;
  logic [WIDTH-1:0] credit [LANES];
  logic [LANES-1:0] zero;
  logic             hs;
  logic             reload;

  assign idx_ready = (state == IDLE) && !refill_req;
  assign hs        = idx_valid && idx_ready;
  assign reload    = (state == REFILL) && (rcnt == LAST);
  assign busy      = (state != IDLE);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    credit_counter #(.WIDTH(WIDTH), .INIT(INIT_CREDIT)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .dec      (hs && (idx == IDX_W'(i))),
      .load     (reload),
      .load_val (WIDTH'(INIT_CREDIT)),
      .count    (credit[i]),
      .zero     (zero[i])
    );
  end

  assign credit_a = credit[0];
  assign credit_b = credit[1];
  assign credit_c = credit[2];
  assign credit_d = credit[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rcnt        <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_err   <= 1'b0;
    end else begin
      // Grant outputs are a one-cycle pulse: cleared unless IDLE sets them.
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (refill_req) begin
            state <= REFILL;
          end else if (hs) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_err   <= zero[idx];
            grant       <= zero[idx] ? '0 : onehot(idx);
          end
        end
        GRANT:  state <= (&zero) ? REFILL : IDLE;
        REFILL: begin
          if (rcnt == LAST) begin
            rcnt  <= '0;
            state <= IDLE;
          end else begin
            rcnt <= rcnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_credit_dispatch.sv
// Directed scoreboard bench for credit_dispatch: stimulus queues expected
// grants, a negedge monitor pops and compares them.
module tb_credit_dispatch;

  logic       clk = 1'b0;
  logic       reset;
  logic       idx_valid;
  logic [1:0] idx;
  logic       idx_ready;
  logic       refill_req;
  logic [2:0] credit_a, credit_b, credit_c, credit_d;
  logic [3:0] grant;
  logic       grant_valid;
  logic       grant_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] grant;
    logic       err;
    logic [1:0] lane;
    logic [2:0] credit;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  credit_dispatch dut (
    .clk         (clk),
    .reset       (reset),
    .idx_valid   (idx_valid),
    .idx         (idx),
    .idx_ready   (idx_ready),
    .refill_req  (refill_req),
    .credit_a    (credit_a),
    .credit_b    (credit_b),
    .credit_c    (credit_c),
    .credit_d    (credit_d),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_err   (grant_err),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] lane_credit(input logic [1:0] l);
    case (l)
      2'd0:    return credit_a;
      2'd1:    return credit_b;
      2'd2:    return credit_c;
      default: return credit_d;
    endcase
  endfunction

  task automatic check_credits(input string name, input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] c, input logic [2:0] d);
    check({name, "_a"}, credit_a, a);
    check({name, "_b"}, credit_b, b);
    check({name, "_c"}, credit_c, c);
    check({name, "_d"}, credit_d, d);
  endtask

  // Called at a negedge; returns at the negedge inside the GRANT cycle.
  task automatic send(input logic [1:0] i, input logic [3:0] g, input logic e, input logic [2:0] c);
    for (int t = 0; t < 20 && !idx_ready; t++) @(negedge clk);
    if (!idx_ready) check("ready_timeout", 32'(idx_ready), 1);
    idx       = i;
    idx_valid = 1'b1;
    sb.push_back('{grant: g, err: e, lane: i, credit: c});
    @(negedge clk);
    idx_valid = 1'b0;
  endtask

  // Monitor: every grant_valid pulse must match the head of the scoreboard.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (grant_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_grant", 32'(grant), 0);
        end else begin
          x = sb.pop_front();
          check("grant", 32'(grant), 32'(x.grant));
          check("grant_err", 32'(grant_err), 32'(x.err));
          check("grant_credit", 32'(lane_credit(x.lane)), 32'(x.credit));
          check("grant_ready_low", 32'(idx_ready), 0);
        end
      end else begin
        check("no_grant_outputs", {27'd0, grant, grant_err}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    idx_valid  = 1'b0;
    idx        = 2'd0;
    refill_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reset state
    check_credits("reset", 7, 7, 7, 7);
    check("reset_ready", 32'(idx_ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_gv", 32'(grant_valid), 0);

    // 2: single index on lane c
    send(2'd2, 4'b0100, 1'b0, 3'd6);
    check("t2_busy_in_grant", 32'(busy), 1);
    @(negedge clk);
    check("t2_ready_after", 32'(idx_ready), 1);
    check_credits("t2", 7, 7, 6, 7);

    // 3: idx_valid held for 14 handshakes on lane a
    idx       = 2'd0;
    idx_valid = 1'b1;
    for (int k = 1; k <= 14; k++)
      sb.push_back('{grant: (k >= 8) ? 4'b0000 : 4'b0001, err: (k >= 8),
                     lane: 2'd0, credit: (k >= 7) ? 3'd0 : 3'(7 - k)});
    repeat (28) @(negedge clk);
    idx_valid = 1'b0;
    @(negedge clk);
    check("t3_sb_drained", sb.size(), 0);
    check_credits("t3", 0, 7, 6, 7);

    // 4: drain b, c, d; the last grant triggers automatic refill
    for (int k = 1; k <= 7; k++) send(2'd1, 4'b0010, 1'b0, 3'(7 - k));
    for (int k = 1; k <= 6; k++) send(2'd2, 4'b0100, 1'b0, 3'(6 - k));
    for (int k = 1; k <= 7; k++) send(2'd3, 4'b1000, 1'b0, 3'(7 - k));
    idx       = 2'd3;
    idx_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      if (r == 3) idx_valid = 1'b0;
      check("t4_refill_ready", 32'(idx_ready), 0);
      check("t4_refill_busy", 32'(busy), 1);
    end
    @(negedge clk);
    check_credits("t4_reload", 7, 7, 7, 7);
    check("t4_idle_busy", 32'(busy), 0);
    check("t4_idle_ready", 32'(idx_ready), 1);

    // 5: refill_req beats idx_valid in the same IDLE cycle
    send(2'd1, 4'b0010, 1'b0, 3'd6);
    @(negedge clk);
    idx        = 2'd1;
    idx_valid  = 1'b1;
    refill_req = 1'b1;
    #1 check("t5_ready_low", 32'(idx_ready), 0);
    @(negedge clk);
    idx_valid  = 1'b0;
    refill_req = 1'b0;
    check("t5_busy", 32'(busy), 1);
    check("t5_credit_b_kept", 32'(credit_b), 6);
    repeat (3) @(negedge clk);
    check("t5_still_refill", 32'(busy), 1);
    @(negedge clk);
    check_credits("t5_reload", 7, 7, 7, 7);
    check("t5_idle", 32'(busy), 0);

    // 6: reset on the second REFILL cycle after partial drain
    for (int k = 1; k <= 4; k++) send(2'd0, 4'b0001, 1'b0, 3'(7 - k));
    @(negedge clk);
    refill_req = 1'b1;
    @(negedge clk);
    refill_req = 1'b0;
    check("t6_credit_a", 32'(credit_a), 3);
    @(negedge clk);
    check("t6_in_refill", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_credits("t6_reset", 7, 7, 7, 7);
    check("t6_busy", 32'(busy), 0);
    check("t6_gv", 32'(grant_valid), 0);
    check("t6_ready", 32'(idx_ready), 1);

    repeat (2) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
